qchannel_controller: RTL
========================

Name: qchannel_controller

Overview:
- Q-Channel initiator (controller side) that drives a quiescence-capable device such as the picorv32 Q-channel device wrapper.
- Watches device idleness and system wake sources, and requests quiescence after a programmable idle period.
- Completes the qreqn/qacceptn/qdeny handshake and drives a clock-gate enable for the device.
- Sits in the power-management block, one instance per gated core.

Parameters:
- IDLE_CYCLES, 16, consecutive qualifying idle cycles before qreqn is lowered (1..65535).
- CNT_W, 16, width of the idle counter.
- SYNC_STAGES, 0, flop stages on qacceptn/qdeny (0 = same-clock direct use, 2 = async device).
- BOOT_RUN, 1, 1 = leave the reset-stopped state automatically on the first cycle after reset release.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- resetn  in  1  asynchronous active-low reset, clears all state immediately.
- pwr_allow  in  1  software permission to power down; 0 blocks new requests.
- dev_idle  in  1  device-side idle hint (no outstanding bus or PCPI traffic).
- wake  in  1  level wake source (irq pending, debug, bus access to device).
- qreqn  out  1  quiescence request, active low.
- qacceptn  in  1  device accept, active low.
- qdeny  in  1  device deny.
- clk_en  out  1  device clock-gate enable.
- q_state  out  3  encoded controller state.
- deny_cnt  out  8  saturating count of denied requests.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Inputs: qa/qd are qacceptn/qdeny after SYNC_STAGES flops; reset value of qa/qd is 0.
- Reset values: qreqn=0, clk_en=1, q_state=Q_STOPPED, deny_cnt=0, proto_err=0, idle_cnt=0.
- State encodings: Q_STOPPED=0, Q_EXIT=1, Q_RUN=2, Q_REQUEST=3, Q_DENIED=4, Q_CONTINUE=5.
- qreqn is registered: 1 in Q_EXIT, Q_RUN, Q_CONTINUE; 0 otherwise.
- Q_STOPPED -> Q_EXIT:
  - when wake=1, or on the first cycle after reset if BOOT_RUN=1;
  - clk_en rises on the same edge as qreqn.
- Q_EXIT -> Q_RUN: when qa=1. idle_cnt cleared.
- Q_RUN idle counting:
  - qualify = dev_idle & pwr_allow & !wake;
  - idle_cnt increments while qualify=1, saturates at IDLE_CYCLES, clears to 0 on any non-qualifying cycle.
- Q_RUN -> Q_REQUEST: on the cycle idle_cnt==IDLE_CYCLES-1 with qualify=1. With IDLE_CYCLES=16, qreqn falls at the edge after the 16th consecutive qualifying cycle.
- Q_REQUEST: qreqn is held low; wake does not withdraw the request (protocol forbids it).
  - qa=0 and qd=0 -> Q_STOPPED; clk_en=0 on that same edge.
  - qd=1 (qa=1) -> Q_DENIED; deny_cnt increments, saturating at 255.
  - qa=0 and qd=1 in the same cycle -> proto_err=1, treated as deny.
- Q_STOPPED with wake already pending on entry: the stop lasts exactly one cycle before Q_EXIT (minimum stop 1 cycle).
- Q_DENIED -> Q_CONTINUE: next cycle unconditionally; qreqn rises.
- Q_CONTINUE -> Q_RUN: when qd=0; idle_cnt cleared, so the next request needs a full new idle period.
- proto_err is set (sticky until reset) on any of:
  - qa falls while qreqn=1;
  - qa=1 while in Q_STOPPED;
  - qd=1 in Q_RUN or Q_STOPPED.
- pwr_allow falling during Q_REQUEST has no effect on the handshake in flight.
- Async reset mid-handshake forces the reset values at once. The device resets to its own stopped state (qacceptn=0), so both sides stay consistent. clk_en=1 during and after reset so the device's synchronous reset is clocked.

Decomposition:
- Shared package qchannel_pkg: state encodings, state typedef, deny counter width (8).
- Sub-module qchannel_sync: parameterised SYNC_STAGES flop chain with bypass at 0. Instantiated twice, for qacceptn and qdeny.

Test Plan:
- Reset release, BOOT_RUN=1, device stub accepts in 1 cycle -> qreqn=1 at cycle 1, q_state=Q_RUN at cycle 2, clk_en=1 throughout.
- Q_RUN, dev_idle=1, pwr_allow=1, wake=0 for 16 cycles -> qreqn=0 after the 16th. Stub drops qacceptn 3 cycles later -> Q_STOPPED, clk_en=0 on the same edge.
- Idle run of 10 cycles, one busy cycle, then idle 16 -> no request until 16 consecutive idle cycles counted after the break.
- Stub asserts qdeny in Q_REQUEST -> deny_cnt=1, qreqn=1 next cycle, Q_RUN once qdeny=0. 300 denies -> deny_cnt=255.
- wake=1 at the cycle qreqn falls -> handshake completes to Q_STOPPED, one cycle stopped, then Q_EXIT, qreqn=1, clk_en=1.
- Stub drops qacceptn while qreqn=1, and separately asserts qdeny in Q_RUN -> proto_err=1, held until resetn=0. Mid-Q_REQUEST resetn pulse -> qreqn=0, q_state=0, deny_cnt=0 asynchronously.

Source files
------------

// File: rtl/qchannel_pkg.sv
// Shared definitions for the Q-Channel controller.
// State encodings and deny counter sizing.
package qchannel_pkg;

    typedef enum logic [2:0] {
        Q_STOPPED  = 3'd0,
        Q_EXIT     = 3'd1,
        Q_RUN      = 3'd2,
        Q_REQUEST  = 3'd3,
        Q_DENIED   = 3'd4,
        Q_CONTINUE = 3'd5
    } q_state_e;

    localparam int DENY_W = 8;
    localparam logic [DENY_W-1:0] DENY_MAX = '1;

endpackage

// File: rtl/qchannel_sync.sv
// Reset-to-zero flop chain for device handshake inputs.
// STAGES=0 passes the input straight through.
module qchannel_sync #(
    parameter int STAGES = 0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    if (STAGES == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ resetn;
        assign q = d;
    end else begin : g_chain
        logic [STAGES-1:0] sync_d;
        logic [STAGES-1:0] sync_q;

        always_comb begin
            sync_d[0] = d;
            for (int i = 1; i < STAGES; i++) begin
                sync_d[i] = sync_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                sync_q <= '0;
            end else begin
                sync_q <= sync_d;
            end
        end

        assign q = sync_q[STAGES-1];
    end

endmodule

// File: rtl/qchannel_controller.sv
// Q-Channel initiator: idle-timed quiescence requests,
// handshake completion and device clock-gate control.
module qchannel_controller
    import qchannel_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 0,
    parameter int BOOT_RUN    = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pwr_allow,
    input  logic       dev_idle,
    input  logic       wake,
    output logic       qreqn,
    input  logic       qacceptn,
    input  logic       qdeny,
    output logic       clk_en,
    output logic [2:0] q_state,
    output logic [7:0] deny_cnt,
    output logic       proto_err
);

    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    logic qa;
    logic qd;

    qchannel_sync #(.STAGES(SYNC_STAGES)) u_sync_qa (
        .clk    (clk),
        .resetn (resetn),
        .d      (qacceptn),
        .q      (qa)
    );

    qchannel_sync #(.STAGES(SYNC_STAGES)) u_sync_qd (
        .clk    (clk),
        .resetn (resetn),
        .d      (qdeny),
        .q      (qd)
    );

    q_state_e          state_q, state_d;
    logic              qreqn_q, qreqn_d;
    logic              clk_en_q, clk_en_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [DENY_W-1:0] deny_cnt_q, deny_cnt_d;
    logic              proto_err_q, proto_err_d;
    logic              boot_q, boot_d;
    logic              qa_prev_q, qa_prev_d;
    logic              qualify;
    logic              perr_set;

    always_comb begin
        state_d    = state_q;
        clk_en_d   = clk_en_q;
        idle_cnt_d = idle_cnt_q;
        deny_cnt_d = deny_cnt_q;
        boot_d     = 1'b0;
        qa_prev_d  = qa;
        qualify    = dev_idle & pwr_allow & ~wake;

        unique case (state_q)
            Q_STOPPED: begin
                if (wake || ((BOOT_RUN != 0) && boot_q)) begin
                    state_d  = Q_EXIT;
                    clk_en_d = 1'b1;
                end
            end
            Q_EXIT: begin
                if (qa) begin
                    state_d    = Q_RUN;
                    idle_cnt_d = '0;
                end
            end
            Q_RUN: begin
                if (!qualify) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != IDLE_MAX) begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end
                if (qualify && (idle_cnt_q == IDLE_LAST)) begin
                    state_d = Q_REQUEST;
                end
            end
            // Once lowered, qreqn stays low until the device answers.
            Q_REQUEST: begin
                if (qd) begin
                    state_d = Q_DENIED;
                    if (deny_cnt_q != DENY_MAX) begin
                        deny_cnt_d = deny_cnt_q + DENY_W'(1);
                    end
                end else if (!qa) begin
                    state_d  = Q_STOPPED;
                    clk_en_d = 1'b0;
                end
            end
            Q_DENIED: begin
                state_d = Q_CONTINUE;
            end
            Q_CONTINUE: begin
                if (!qd) begin
                    state_d    = Q_RUN;
                    idle_cnt_d = '0;
                end
            end
            default: begin
                state_d = Q_STOPPED;
            end
        endcase

        perr_set = (qa_prev_q & ~qa & qreqn_q)
                 | (qa & (state_q == Q_STOPPED))
                 | (qd & ((state_q == Q_RUN) || (state_q == Q_STOPPED)))
                 | (qd & ~qa & (state_q == Q_REQUEST));
        proto_err_d = proto_err_q | perr_set;

        qreqn_d = (state_d == Q_EXIT) || (state_d == Q_RUN)
               || (state_d == Q_CONTINUE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= Q_STOPPED;
            qreqn_q     <= 1'b0;
            clk_en_q    <= 1'b1;
            idle_cnt_q  <= '0;
            deny_cnt_q  <= '0;
            proto_err_q <= 1'b0;
            boot_q      <= 1'b1;
            qa_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            qreqn_q     <= qreqn_d;
            clk_en_q    <= clk_en_d;
            idle_cnt_q  <= idle_cnt_d;
            deny_cnt_q  <= deny_cnt_d;
            proto_err_q <= proto_err_d;
            boot_q      <= boot_d;
            qa_prev_q   <= qa_prev_d;
        end
    end

    assign qreqn     = qreqn_q;
    assign clk_en    = clk_en_q;
    assign q_state   = state_q;
    assign deny_cnt  = deny_cnt_q;
    assign proto_err = proto_err_q;

endmodule
